// File: rtl/sobel_nms.sv
// Streaming non-maximum suppression for Canny: 3x3 window over two line buffers,
// keeps a magnitude only if it is a local maximum along its quantized gradient direction.
module sobel_nms #(
  parameter int unsigned NBIT_MAG   = 11,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [NBIT_MAG-1:0] i_mag,
  input  logic [1:0]          i_dir,
  output logic                o_ready,
  output logic                o_valid,
  output logic [NBIT_MAG-1:0] o_mag,
  output logic                o_eof
);

  localparam int unsigned PW = NBIT_MAG + 2;
  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam int unsigned FW = $clog2(IMG_WIDTH + 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] in_col, out_col;
  logic [RW-1:0] in_row, out_row;
  logic [FW-1:0] flush_cnt;

  // lb1 holds the previous line with direction; lb2 the line before it (magnitude only).
  logic [PW-1:0]       lb1 [IMG_WIDTH];
  logic [NBIT_MAG-1:0] lb2 [IMG_WIDTH];

  // Window columns: win_a is column c-2, win_b is column c-1; index 0 = top row.
  logic [NBIT_MAG-1:0] win_a [3];
  logic [NBIT_MAG-1:0] win_b [3];
  logic [1:0]          cen_dir;

  logic                accept, adv, emit, border, keep, last_out;
  logic [PW-1:0]       pix, up;
  logic [NBIT_MAG-1:0] up2, cen, n1, n2;

  assign o_ready = (state == RUN);
  assign accept  = i_valid && o_ready;
  assign adv     = accept || (state == FLUSH);
  assign pix     = o_ready ? {i_mag, i_dir} : '0;
  assign up      = lb1[in_col];
  assign up2     = lb2[in_col];
  assign cen     = win_b[1];

  // Incoming column (up2, up, pix) supplies the east-side neighbours of the center.
  always_comb begin
    n1 = '0;
    n2 = '0;
    unique case (cen_dir)
      2'b00: begin n1 = win_a[1]; n2 = up[PW-1:2]; end
      2'b01: begin n1 = win_b[0]; n2 = win_b[2];   end
      2'b10: begin n1 = up2;      n2 = win_a[2];   end
      2'b11: begin n1 = win_a[0]; n2 = pix[PW-1:2]; end
      default: ;
    endcase
  end

  assign keep     = (n1 < cen) && (n2 <= cen);
  assign border   = (out_row == '0) || (out_row == ROW_LAST) ||
                    (out_col == '0) || (out_col == COL_LAST);
  assign last_out = (out_row == ROW_LAST) && (out_col == COL_LAST);
  assign emit     = (state == FLUSH) ||
                    (accept && ((in_row == RW'(1) && in_col != '0) || (in_row > RW'(1))));

  always_ff @(posedge i_clk) begin
    if (adv) begin
      lb1[in_col] <= pix;
      lb2[in_col] <= up[PW-1:2];
      win_a       <= win_b;
      win_b[0]    <= up2;
      win_b[1]    <= up[PW-1:2];
      win_b[2]    <= pix[PW-1:2];
      cen_dir     <= up[1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= RUN;
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      flush_cnt <= '0;
      o_valid   <= 1'b0;
      o_mag     <= '0;
      o_eof     <= 1'b0;
    end else begin
      o_valid <= emit;
      o_mag   <= (emit && keep && !border) ? cen : '0;
      o_eof   <= emit && last_out;

      if (emit) begin
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end

      if (state == RUN) begin
        if (accept) begin
          if (in_col == COL_LAST) begin
            in_col <= '0;
            if (in_row == ROW_LAST) begin
              in_row    <= '0;
              flush_cnt <= '0;
              state     <= FLUSH;
            end else begin
              in_row <= in_row + 1'b1;
            end
          end else begin
            in_col <= in_col + 1'b1;
          end
        end
      end else begin
        // Zero virtual pixels drain the last line; the final cycle also overrides out_* above.
        if (flush_cnt == FLUSH_LAST) begin
          state     <= RUN;
          flush_cnt <= '0;
          in_col    <= '0;
          in_row    <= '0;
          out_col   <= '0;
          out_row   <= '0;
        end else begin
          flush_cnt <= flush_cnt + 1'b1;
          in_col    <= (in_col == COL_LAST) ? '0 : in_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_nms.sv
// Directed bench for sobel_nms on an 8x6 frame with hand-derived expected images.
module tb_sobel_nms;

  localparam int NB = 11;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_valid = 1'b0;
  logic [NB-1:0] i_mag = '0;
  logic [1:0]    i_dir = '0;
  logic          o_ready, o_valid, o_eof;
  logic [NB-1:0] o_mag;

  sobel_nms #(.NBIT_MAG(NB), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .i_mag   (i_mag),
    .i_dir   (i_dir),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_mag   (o_mag),
    .o_eof   (o_eof)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int drive_stalls = 0;

  logic [NB-1:0] img_mag [N];
  logic [1:0]    img_dir [N];
  logic [NB-1:0] exp_mag [N];

  int            cap_n = 0;
  logic [NB-1:0] cap_mag [256];
  logic          cap_eof [256];
  int            ready_run = 0;
  int            runs [$];

  always @(posedge clk) begin
    #1;
    if (o_valid) begin
      if (cap_n < 256) begin
        cap_mag[cap_n] = o_mag;
        cap_eof[cap_n] = o_eof;
      end
      cap_n++;
    end
    if (!o_ready) ready_run++;
    else if (ready_run > 0) begin
      runs.push_back(ready_run);
      ready_run = 0;
    end
  end

  task automatic clear_capture();
    cap_n = 0;
    ready_run = 0;
    runs.delete();
    drive_stalls = 0;
    for (int i = 0; i < 256; i++) begin
      cap_mag[i] = 'x;
      cap_eof[i] = 1'bx;
    end
  endtask

  task automatic fill(input logic [NB-1:0] bg, input logic [1:0] d);
    for (int i = 0; i < N; i++) begin
      img_mag[i] = bg;
      img_dir[i] = d;
      exp_mag[i] = '0;
    end
  endtask

  task automatic drive_frame(input bit gaps, input int npix);
    int g;
    int tries;
    bit acc;
    for (int i = 0; i < npix; i++) begin
      @(negedge clk);
      if (gaps) begin
        g = $urandom_range(0, 2);
        if (g != 0) begin
          i_valid = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      i_valid = 1'b1;
      i_mag   = img_mag[i];
      i_dir   = img_dir[i];
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 64) begin
        if (tries > 0) @(negedge clk);
        acc = o_ready;
        tries++;
        @(posedge clk);
      end
      if (!acc) drive_stalls++;
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int k;
    k = 0;
    while (cap_n < n && k < 1000) begin
      @(posedge clk);
      k++;
    end
    repeat (12) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    int eofs;
    #1 rst_n = 1'b0;
    #1;
    tests += 4;
    if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_valid); end
    if (o_mag !== '0)     begin fails++; $display("FAIL reset_mag got %0d want 0", o_mag); end
    if (o_eof !== 1'b0)   begin fails++; $display("FAIL reset_eof got %b want 0", o_eof); end
    if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", o_ready); end
    @(negedge clk) rst_n = 1'b1;
    // Abort a frame after 20 pixels, then reset mid-stream.
    fill(11'd7, 2'b00);
    drive_frame(1'b0, 20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests += 4;
    if (o_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid got %b want 0", o_valid); end
    if (o_mag !== '0)     begin fails++; $display("FAIL midreset_mag got %0d want 0", o_mag); end
    if (o_eof !== 1'b0)   begin fails++; $display("FAIL midreset_eof got %b want 0", o_eof); end
    if (o_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready got %b want 1", o_ready); end
    @(negedge clk) rst_n = 1'b1;
    clear_capture();
    fill(11'd10, 2'b00);
    img_mag[19] = 11'd100;
    exp_mag[19] = 11'd100;
    drive_frame(1'b0, N);
    wait_outputs(N);
    tests++;
    if (cap_n !== N) begin fails++; $display("FAIL post_reset_count got %0d want %0d", cap_n, N); end
    eofs = 0;
    for (int i = 0; i < N; i++) if (cap_eof[i] === 1'b1) eofs++;
    tests += 2;
    if (eofs !== 1) begin fails++; $display("FAIL post_reset_eof_count got %0d want 1", eofs); end
    if (cap_eof[N-1] !== 1'b1) begin fails++; $display("FAIL post_reset_eof_last got %b want 1", cap_eof[N-1]); end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (cap_mag[i] !== exp_mag[i]) begin
        fails++;
        $display("FAIL post_reset_mag[%0d] got %0d want %0d", i, cap_mag[i], exp_mag[i]);
      end
    end
  endtask

  task automatic test_flat();
    clear_capture();
    fill(11'd5, 2'b00);
    drive_frame(1'b0, N);
    wait_outputs(N);
    tests++;
    if (cap_n !== N) begin fails++; $display("FAIL flat_count got %0d want %0d", cap_n, N); end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (cap_mag[i] !== 11'd0) begin
        fails++;
        $display("FAIL flat_mag[%0d] got %0d want 0", i, cap_mag[i]);
      end
    end
  endtask

  task automatic test_direction();
    for (int t = 0; t < 4; t++) begin
      clear_capture();
      if (t < 2) begin
        fill(11'd10, (t == 0) ? 2'b00 : 2'b01);
        for (int r = 0; r < H; r++) img_mag[r*W+3] = 11'd50;
        if (t == 0) for (int r = 1; r < H - 1; r++) exp_mag[r*W+3] = 11'd50;
      end else begin
        fill(11'd10, (t == 2) ? 2'b11 : 2'b10);
        for (int r = 0; r < H; r++) img_mag[r*W+r] = 11'd60;
        if (t == 3) for (int r = 1; r < H - 1; r++) exp_mag[r*W+r] = 11'd60;
      end
      drive_frame(1'b0, N);
      wait_outputs(N);
      tests++;
      if (cap_n !== N) begin fails++; $display("FAIL dir%0d_count got %0d want %0d", t, cap_n, N); end
      for (int i = 0; i < N; i++) begin
        tests++;
        if (cap_mag[i] !== exp_mag[i]) begin
          fails++;
          $display("FAIL dir%0d_mag[%0d] got %0d want %0d", t, i, cap_mag[i], exp_mag[i]);
        end
      end
    end
  endtask

  task automatic test_tie();
    clear_capture();
    fill(11'd10, 2'b00);
    img_mag[19] = 11'd80;
    img_mag[20] = 11'd80;
    drive_frame(1'b0, N);
    wait_outputs(N);
    tests += 3;
    if (cap_n !== N) begin fails++; $display("FAIL tie_count got %0d want %0d", cap_n, N); end
    if (cap_mag[19] !== 11'd80) begin fails++; $display("FAIL tie_first got %0d want 80", cap_mag[19]); end
    if (cap_mag[20] !== 11'd0)  begin fails++; $display("FAIL tie_second got %0d want 0", cap_mag[20]); end
  endtask

  task automatic test_back_to_back();
    int eofs;
    clear_capture();
    fill(11'd10, 2'b00);
    img_mag[19] = 11'd80;
    img_mag[20] = 11'd80;
    drive_frame(1'b1, N);
    fill(11'd10, 2'b00);
    img_mag[19] = 11'd100;
    exp_mag[19] = 11'd100;
    drive_frame(1'b1, N);
    wait_outputs(2 * N);
    tests += 8;
    if (drive_stalls !== 0) begin fails++; $display("FAIL b2b_stalls got %0d want 0", drive_stalls); end
    if (cap_n !== 2 * N) begin fails++; $display("FAIL b2b_count got %0d want %0d", cap_n, 2 * N); end
    if (runs.size() !== 2) begin fails++; $display("FAIL b2b_ready_runs got %0d want 2", runs.size()); end
    if (runs.size() > 0 && runs[0] !== W + 1) begin
      fails++; $display("FAIL b2b_ready_low0 got %0d want %0d", runs[0], W + 1);
    end
    if (runs.size() > 1 && runs[1] !== W + 1) begin
      fails++; $display("FAIL b2b_ready_low1 got %0d want %0d", runs[1], W + 1);
    end
    eofs = 0;
    for (int i = 0; i < 2 * N; i++) if (cap_eof[i] === 1'b1) eofs++;
    if (eofs !== 2) begin fails++; $display("FAIL b2b_eof_count got %0d want 2", eofs); end
    if (cap_eof[N-1] !== 1'b1) begin fails++; $display("FAIL b2b_eof0 got %b want 1", cap_eof[N-1]); end
    if (cap_mag[19] !== 11'd80) begin fails++; $display("FAIL b2b_f0_tie got %0d want 80", cap_mag[19]); end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (cap_mag[N+i] !== exp_mag[i]) begin
        fails++;
        $display("FAIL b2b_f1_mag[%0d] got %0d want %0d", i, cap_mag[N+i], exp_mag[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_direction();
    test_tie();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sobel_nms.md
# sobel_nms

Streaming non-maximum suppression stage for the Canny pipeline. It consumes per-pixel gradient magnitude and the 2-bit quantized gradient direction produced by the Sobel/arctangent stage. Each pixel is kept only if it is a local maximum along its gradient direction. Internally it buffers two image lines to build a 3x3 window, emits one thinned magnitude per input pixel in raster order, and self-flushes the final line at end of frame.

## Interface
- NBIT_MAG, 11: magnitude width (unsigned)
- IMG_WIDTH, 640: pixels per line (≥ 3)
- IMG_HEIGHT, 480: lines per frame (≥ 3)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  input pixel valid; accepted when i_valid && o_ready
- i_mag  in  NBIT_MAG  gradient magnitude, unsigned
- i_dir  in  2  quantized direction: 00 = 0°, 01 = 90°, 10 = 45°, 11 = 135°
- o_ready  out  1  block accepts input; low only during FLUSH
- o_valid  out  1  output pixel valid, one-cycle pulse per pixel
- o_mag  out  NBIT_MAG  thinned magnitude (center magnitude or 0)
- o_eof  out  1  high with o_valid on the last output pixel of a frame

## Operation
- Frame = IMG_WIDTH*IMG_HEIGHT accepted pixels in raster order. There is no sof input; frame position comes from internal col/row counters. Input gaps (i_valid low) are allowed anywhere. The window advances only on accept.
- Two line buffers of IMG_WIDTH entries store {mag, dir}. A 3x3 register window holds rows r-1, r, r+1.
- Center pixel n = (r,c) is evaluated when raster pixel n+IMG_WIDTH+1 is accepted.
- Neighbor pair by center dir. The first neighbor listed is earlier in raster order and must be strictly less than the center. The second must be less than or equal to the center.
  - 00: W, E
  - 01: N, S
  - 10: NE, SW
  - 11: NW, SE
- o_mag = center mag when both conditions hold, else 0.
- Border pixels (r=0, r=IMG_HEIGHT-1, c=0, c=IMG_WIDTH-1) always output 0. They are never compared, and out-of-frame neighbors are never read.
- Downstream is always ready. There is no output backpressure.
- FSM:
  - RUN (reset state): o_ready=1. On acceptance of the last frame pixel, go to FLUSH.
  - FLUSH: o_ready=0. Inject IMG_WIDTH+1 zero-valued virtual pixels, one per cycle. This emits the remaining IMG_WIDTH+1 outputs, the last with o_eof.
  - Then clear all counters and go to RUN. The next frame may start on the following cycle.
- Counters: input col wraps at IMG_WIDTH-1 and increments row. Row wraps at IMG_HEIGHT-1 into FLUSH. The output-side col/row is derived identically to drive the border mask and o_eof.
- Magnitude comparison is unsigned at NBIT_MAG bits. No arithmetic widening.

## Timing
- Reset (async assert): o_valid=0, o_mag=0, o_eof=0, o_ready=1, state=RUN, all counters 0.
  - Line buffer and window contents are not cleared. Masking guarantees stale data never reaches o_mag.
- Reset mid-frame aborts the frame with no further outputs. The next accepted pixel is pixel (0,0).
- Outputs are registered. o_valid for center n rises the cycle after pixel n+IMG_WIDTH+1 is accepted.
- The first IMG_WIDTH+1 accepts of a frame produce no output.
- Every frame yields exactly IMG_WIDTH*IMG_HEIGHT o_valid pulses.
- FLUSH lasts exactly IMG_WIDTH+1 cycles. o_valid is high on each of those cycles, delayed by 1. o_eof is on the last pulse.
- o_ready rises in the cycle after the final FLUSH cycle. Any i_valid asserted while o_ready=0 is ignored and must be held by the source.
- Throughput: 1 pixel/cycle sustained in RUN.

## Test plan
- Reset: assert i_rst_n=0 mid-stream → o_valid=0, o_mag=0, o_eof=0, o_ready=1. After release, an 8x6 frame produces exactly 48 outputs with o_eof on the 48th.
- Flat field, IMG_WIDTH=8, IMG_HEIGHT=6, all mag=5, dir=00 → all 48 outputs are 0 (strict W compare fails).
- Single peak, 8x6: mag=100 at (2,3), all others 10, dir=00 everywhere → o_mag=100 only at raster index 19, all other outputs 0.
- Direction selectivity, 8x6: column 3 = 50, others 10.
  - dir=00 → rows 1–4 of column 3 output 50, everything else 0.
  - Same image with dir=01 → all outputs 0.
  - Diagonal ridge r=c with mag 60 and dir=11 → interior diagonal outputs 0. Same ridge with dir=10 → interior diagonal outputs 60.
- Tie break, 8x6: (2,3)=(2,4)=80, others 10, dir=00 → output 80 at (2,3), 0 at (2,4).
- Flow control, 8x6, two back-to-back frames with random i_valid gaps:
  - o_ready low for exactly 9 cycles after each frame's last accept.
  - 48 outputs per frame, o_eof once per frame.
  - Second frame's results are identical to the gap-free reference.
